// File: rtl/keypad_scanner_pkg.sv
// keypad_scanner_pkg: shared keymap, FSM states and scan-result encodings
package keypad_scanner_pkg;
   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_HELD} state_t;
   typedef enum logic [1:0] {R_NONE, R_ONE, R_MULTI} result_t;
   // nibble {col,row}: col0=1,4,7,0 col1=2,5,8,F col2=3,6,9,E col3=A,B,C,D
   localparam logic [63:0] KEYMAP = 64'hDCBA_E963_F852_0741;
   function automatic logic [3:0] key_of(input logic [3:0] idx);
      return KEYMAP[{idx, 2'b00} +: 4];
   endfunction
endpackage

// File: rtl/keypad_scanner_scan_timer.sv
// scan_timer: column dwell counter and column index; drives one active-low column at a time
module scan_timer #(
   parameter int SCAN_CYCLES = 100_000
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   output logic [3:0] o_col,
   output logic       o_sample,
   output logic       o_scan_done
);
   localparam int CW = $clog2(SCAN_CYCLES);
   logic [CW-1:0] r_cnt;
   logic [1:0]    r_col;
   assign o_sample    = r_cnt == CW'(SCAN_CYCLES - 1);
   assign o_scan_done = o_sample && r_col == 2'd3;
   assign o_col       = ~(4'b0001 << r_col);
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
         r_col <= '0;
      end else if (o_sample) begin
         r_cnt <= '0;
         r_col <= r_col + 2'd1;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scan, debounce and hex entry register
module keypad_scanner
   import keypad_scanner_pkg::*;
#(
   parameter int SCAN_CYCLES    = 100_000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [3:0]  i_row,
   output logic [3:0]  o_col,
   output logic        o_key_valid,
   output logic [3:0]  o_key_code,
   output logic        o_key_held,
   output logic [15:0] o_number
);
   localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_SCANS);
   logic          w_sample, w_scan_done;
   logic [15:0]   w_hits;
   logic [4:0]    w_n;
   logic [3:0]    w_idx, w_key;
   result_t       w_res;
   logic [DW-1:0] w_cnt_inc, w_rel_inc;
   logic [3:0]    r_row_s1, r_row_s2;
   logic [11:0]   r_hits;
   state_t        r_state;
   logic [3:0]    r_cand;
   logic [DW-1:0] r_cnt, r_rel;
   logic          r_key_valid;
   logic [3:0]    r_key_code;
   logic [15:0]   r_number;
   scan_timer #(.SCAN_CYCLES(SCAN_CYCLES)) u_timer (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .o_col       (o_col),
      .o_sample    (w_sample),
      .o_scan_done (w_scan_done)
   );
   // columns 0..2 shift in so the column-3 capture completes the 16-bit {col,row} map
   assign w_hits    = {~r_row_s2, r_hits};
   assign w_key     = key_of(w_idx);
   assign w_res     = w_n == 5'd0 ? R_NONE : w_n == 5'd1 ? R_ONE : R_MULTI;
   assign w_cnt_inc = r_cnt == DB_MAX ? r_cnt : r_cnt + DW'(1);
   assign w_rel_inc = r_rel == DB_MAX ? r_rel : r_rel + DW'(1);
   always_comb begin
      w_n   = '0;
      w_idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (w_hits[i]) begin
            w_n   = w_n + 5'd1;
            w_idx = 4'(i);
         end
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_row_s1 <= 4'hF;
         r_row_s2 <= 4'hF;
         r_hits   <= '0;
      end else begin
         r_row_s1 <= i_row;
         r_row_s2 <= r_row_s1;
         if (w_sample) r_hits <= {~r_row_s2, r_hits[11:4]};
      end
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_cand      <= '0;
         r_cnt       <= '0;
         r_rel       <= '0;
         r_key_valid <= 1'b0;
         r_key_code  <= '0;
         r_number    <= '0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_scan_done) begin
            case (r_state)
               S_IDLE: if (w_res == R_ONE) begin
                  r_cand <= w_key;
                  r_cnt  <= DW'(1);
                  if (DB_MAX == DW'(1)) begin
                     r_state     <= S_HELD;
                     r_rel       <= '0;
                     r_key_valid <= 1'b1;
                     r_key_code  <= w_key;
                     r_number    <= {r_number[11:0], w_key};
                  end else begin
                     r_state <= S_DEBOUNCE;
                  end
               end
               S_DEBOUNCE: if (w_res != R_ONE) begin
                  r_state <= S_IDLE;
               end else if (w_key != r_cand) begin
                  r_cand <= w_key;
                  r_cnt  <= DW'(1);
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_cnt_inc == DB_MAX) begin
                     r_state     <= S_HELD;
                     r_rel       <= '0;
                     r_key_valid <= 1'b1;
                     r_key_code  <= w_key;
                     r_number    <= {r_number[11:0], w_key};
                  end
               end
               S_HELD: if (w_res == R_NONE) begin
                  r_rel <= w_rel_inc;
                  if (w_rel_inc == DB_MAX) r_state <= S_IDLE;
               end else begin
                  r_rel <= '0;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end
   assign o_key_valid = r_key_valid;
   assign o_key_code  = r_key_code;
   assign o_key_held  = r_state == S_HELD;
   assign o_number    = r_number;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed keypad scenarios with a scoreboard checking every accept pulse
module tb_keypad_scanner;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row, col, kc;
   logic        kv, kh;
   logic [15:0] num;
   logic [15:0] pressed = '0;
   logic [15:0] exp_num = '0;
   logic [19:0] sb[$];
   int total = 0;
   int bad = 0;

   keypad_scanner #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(2)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_row       (row),
      .o_col       (col),
      .o_key_valid (kv),
      .o_key_code  (kc),
      .o_key_held  (kh),
      .o_number    (num)
   );

   always #5 clk = ~clk;

   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            if (pressed[c*4+r] && !col[c]) row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (rst_n && kv) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_pulse got code=%h number=%h exp no pulse", kc, num);
         end else begin
            logic [19:0] e;
            e = sb.pop_front();
            if ({kc, num} !== e) begin
               bad++;
               $display("FAIL pulse got code/number=%h exp=%h", {kc, num}, e);
            end
         end
      end
   end

   task automatic chk(input string n, input logic [19:0] got, input logic [19:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   function automatic logic [15:0] m(input int r, input int c);
      m = 16'(1) << (c * 4 + r);
   endfunction

   task automatic hold(input logic [15:0] k, input int n);
      pressed = k;
      repeat (n) @(negedge clk);
   endtask

   task automatic key(input int r, input int c, input logic [3:0] code);
      exp_num = {exp_num[11:0], code};
      sb.push_back({code, exp_num});
      hold(m(r, c), 48);
      chk("held", 20'(kh), 20'd1);
      chk("code", 20'(kc), 20'(code));
      hold('0, 48);
      chk("released", 20'(kh), 20'd0);
      chk("sb_empty", 20'(sb.size()), 20'd0);
      chk("number", 20'(num), 20'(exp_num));
   endtask

   task automatic async_reset();
      #2 rst_n = 1'b0;
      pressed = '0;
      #1;
      chk("rst_col", 20'(col), 20'hE);
      chk("rst_valid", 20'(kv), 20'd0);
      chk("rst_held", 20'(kh), 20'd0);
      chk("rst_number", 20'(num), 20'd0);
      exp_num = '0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] ec;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (9) @(negedge clk);
      async_reset();
      for (int j = 1; j <= 20; j++) begin
         @(negedge clk);
         ec = ~(4'b0001 << ((j / 4) % 4));
         chk("col_step", 20'(col), 20'(ec));
      end
      key(1, 1, 4'h5);
      key(0, 0, 4'h1);
      key(0, 1, 4'h2);
      key(0, 2, 4'h3);
      key(0, 3, 4'hA);
      chk("num_123A", 20'(num), 20'h0123A);
      key(1, 0, 4'h4);
      chk("num_23A4", 20'(num), 20'h023A4);
      hold(m(2, 0), 12);
      hold('0, 48);
      chk("bounce_number", 20'(num), 20'h023A4);
      exp_num = {exp_num[11:0], 4'h8};
      sb.push_back({4'h8, exp_num});
      hold(m(2, 0), 12);
      hold(m(2, 1), 48);
      chk("held_8", 20'(kh), 20'd1);
      hold('0, 48);
      chk("sb_8", 20'(sb.size()), 20'd0);
      chk("num_3A48", 20'(num), 20'h03A48);
      hold(m(0, 0) | m(0, 1), 48);
      chk("multi_held", 20'(kh), 20'd0);
      hold('0, 48);
      chk("multi_number", 20'(num), 20'h03A48);
      exp_num = {exp_num[11:0], 4'h9};
      sb.push_back({4'h9, exp_num});
      hold(m(2, 2), 48);
      hold(m(2, 2) | m(0, 2), 32);
      hold(m(2, 2), 16);
      hold('0, 8);
      hold(m(2, 2), 48);
      chk("held_9", 20'(kh), 20'd1);
      hold('0, 48);
      chk("sb_9", 20'(sb.size()), 20'd0);
      chk("num_A489", 20'(num), 20'h0A489);
      hold(m(1, 1), 14);
      async_reset();
      hold('0, 48);
      exp_num = {exp_num[11:0], 4'h5};
      sb.push_back({4'h5, exp_num});
      hold(m(1, 1), 48);
      chk("held_pre_rst", 20'(kh), 20'd1);
      async_reset();
      chk("sb_rst", 20'(sb.size()), 20'd0);
      hold('0, 48);
      key(1, 2, 4'h6);
      chk("num_0006", 20'(num), 20'h00006);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
